// File: rtl/wav_frame_loader.sv
// Multi-channel sample frame loader: takes NUM_CH samples per beat, re-times them into a
// one-deep output register, masks the partial final frame and flags run completion.

module wav_lane_mask #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 32,
  parameter int LANE     = 0
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [CNT_W-1:0]    n,
  output logic                keep,
  output logic [SAMPLE_W-1:0] masked
);
  assign keep   = n > CNT_W'(LANE);
  assign masked = keep ? sample : '0;
endmodule

module wav_frame_loader #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  input  logic [CNT_W-1:0]           load_size,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_samples,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*SAMPLE_W-1:0] out_samples,
  output logic [NUM_CH-1:0]          out_keep,
  output logic                       out_last,
  output logic [CNT_W-1:0]           sample_count,
  output logic                       busy,
  output logic                       wav_done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [CNT_W-1:0] CH_CNT = CNT_W'(NUM_CH);

  state_t state, state_nxt;

  logic [NUM_CH-1:0][SAMPLE_W-1:0] lane_in, lane_masked, samples_q;
  logic [NUM_CH-1:0]               keep_nxt, keep_q;
  logic [CNT_W-1:0]                total, rem, n;
  logic                            last_nxt, last_taken;
  logic                            in_fire, out_fire, start_go;

  assign lane_in  = in_samples;
  assign rem      = total - sample_count;
  assign n        = (rem < CH_CNT) ? rem : CH_CNT;
  assign last_nxt = rem <= CH_CNT;

  assign in_ready = (state == STREAM) && !last_taken && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // start is ignored mid-run; clear outranks it in the register process
  assign start_go = start && (state != STREAM);

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_lane
      wav_lane_mask #(
        .SAMPLE_W (SAMPLE_W),
        .CNT_W    (CNT_W),
        .LANE     (k)
      ) u_lane (
        .sample (lane_in[k]),
        .n      (n),
        .keep   (keep_nxt[k]),
        .masked (lane_masked[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (load_size == '0) ? DONE : STREAM;
      STREAM:     if (out_fire && out_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total        <= '0;
      sample_count <= '0;
      samples_q    <= '0;
      keep_q       <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      last_taken   <= 1'b0;
    end else if (clear) begin
      sample_count <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      last_taken   <= 1'b0;
    end else if (start_go) begin
      total        <= load_size;
      sample_count <= '0;
      out_last     <= 1'b0;
      last_taken   <= 1'b0;
    end else if (in_fire) begin
      // an output fire in the same cycle is absorbed: the new frame overwrites the old
      samples_q    <= lane_masked;
      keep_q       <= keep_nxt;
      out_last     <= last_nxt;
      out_valid    <= 1'b1;
      sample_count <= sample_count + n;
      if (last_nxt) last_taken <= 1'b1;
    end else if (out_fire) begin
      out_valid    <= 1'b0;
    end
  end

  assign out_samples = samples_q;
  assign out_keep    = keep_q;
  assign busy        = (state == STREAM);
  assign wav_done    = (state == DONE);
endmodule

// File: tb/tb_wav_frame_loader.sv
// Bench for wav_frame_loader: table of runs plus clear/reset sequences, frames checked
// against a scoreboard filled at input handshake time.

module tb_wav_frame_loader;
  localparam int SW = 16;
  localparam int NC = 8;
  localparam int CW = 32;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0]    load_size = '0;
  logic [NC*SW-1:0] in_samples = '0;
  logic             in_ready, out_valid, out_last, busy, wav_done;
  logic [NC*SW-1:0] out_samples;
  logic [NC-1:0]    out_keep;
  logic [CW-1:0]    sample_count;

  wav_frame_loader #(.SAMPLE_W(SW), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .load_size(load_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_samples(in_samples),
    .out_valid(out_valid), .out_ready(out_ready), .out_samples(out_samples),
    .out_keep(out_keep), .out_last(out_last), .sample_count(sample_count),
    .busy(busy), .wav_done(wav_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC*SW-1:0] s;
    logic [NC-1:0]    k;
    logic             l;
  } frame_t;

  typedef struct {
    logic [CW-1:0] ls;
    int            mode;   // 0 always ready, 1 random valid/ready, 2 five-cycle stall
    int            frames;
    logic [NC-1:0] last_keep;
  } run_t;

  frame_t q[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // reference model and scoreboard, observed on the falling edge
  logic [CW-1:0]    m_total = '0, m_cnt = '0, m_rem, m_n, p_cnt;
  logic [NC*SW-1:0] p_s;
  logic [NC-1:0]    p_k, last_keep = '0;
  logic             p_l, prev_hold = 1'b0, exp_done_next = 1'b0;
  int               frames = 0, act_seen = 0;
  frame_t           fm, fe;

  always @(negedge clk) begin
    if (rst || clear) begin
      q.delete();
      m_cnt = '0;
      exp_done_next = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("count_model", sample_count, m_cnt);
      if (exp_done_next) begin
        chk("done_after_last", {busy, wav_done}, 2'b01);
        exp_done_next = 1'b0;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_samples", out_samples, p_s);
        chk("hold_keep", out_keep, p_k);
        chk("hold_last", out_last, p_l);
        chk("hold_count", sample_count, p_cnt);
      end
      if (out_valid || in_ready) act_seen++;
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame act=keep %0h exp=no frame", out_keep);
        end else begin
          fe = q.pop_front();
          chk("frame_samples", out_samples, fe.s);
          chk("frame_keep", out_keep, fe.k);
          chk("frame_last", out_last, fe.l);
          frames++;
          last_keep = out_keep;
          if (out_last) exp_done_next = 1'b1;
        end
      end
      if (start && !busy) begin
        m_total = load_size;
        m_cnt = '0;
      end else if (in_valid && in_ready) begin
        m_rem = m_total - m_cnt;
        m_n = (m_rem < 32'(NC)) ? m_rem : 32'(NC);
        for (int k = 0; k < NC; k++) begin
          fm.k[k] = (k < m_n);
          fm.s[k*SW +: SW] = (k < m_n) ? in_samples[k*SW +: SW] : '0;
        end
        fm.l = (m_rem <= 32'(NC));
        q.push_back(fm);
        m_cnt = m_cnt + m_n;
      end
      prev_hold = out_valid && !out_ready;
      p_s = out_samples; p_k = out_keep; p_l = out_last; p_cnt = sample_count;
    end
  end

  task automatic rnd_data();
    in_samples = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_start(input logic [CW-1:0] ls);
    start = 1'b1; load_size = ls;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input run_t r);
    int f0, a0, cyc;
    bit done;
    f0 = frames; a0 = act_seen; done = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; rnd_data();
    pulse_start(r.ls);
    chk("cnt_after_start", sample_count, '0);
    if (r.ls == '0) chk("zero_done_next", wav_done, 1'b1);
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (wav_done) begin done = 1'b1; break; end
      if (r.mode == 2 && cyc == 6) chk("stall_count", sample_count, 32'd16);
      rnd_data();
      case (r.mode)
        1:       begin in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); end
        2:       begin in_valid = 1'b1; out_ready = !(cyc >= 2 && cyc < 7); end
        default: begin in_valid = 1'b1; out_ready = 1'b1; end
      endcase
      @(posedge clk); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL run_timeout act=count %0d exp=done for load %0d", sample_count, r.ls);
    end
    chk("run_frames", frames - f0, r.frames);
    if (r.frames > 0) chk("run_last_keep", last_keep, r.last_keep);
    else              chk("zero_no_activity", act_seen - a0, 0);
    chk("run_final_count", sample_count, r.ls);
    chk("run_q_empty", q.size(), 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_in_ready", {in_ready, out_valid, busy, wav_done}, 4'b0001);
    end
    in_valid = 1'b0;
  endtask

  run_t runs[8];

  initial begin
    runs[0] = '{ls: 48000, mode: 0, frames: 6000, last_keep: 8'hFF};
    runs[1] = '{ls: 20,    mode: 0, frames: 3,    last_keep: 8'h0F};
    runs[2] = '{ls: 0,     mode: 0, frames: 0,    last_keep: 8'h00};
    runs[3] = '{ls: 40,    mode: 2, frames: 5,    last_keep: 8'hFF};
    runs[4] = '{ls: 17,    mode: 1, frames: 3,    last_keep: 8'h01};
    runs[5] = '{ls: 1,     mode: 1, frames: 1,    last_keep: 8'h01};
    runs[6] = '{ls: 8,     mode: 0, frames: 1,    last_keep: 8'hFF};
    runs[7] = '{ls: 63,    mode: 1, frames: 8,    last_keep: 8'h7F};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {in_ready, out_valid, out_last, busy, wav_done}, 5'b0);
    chk("rst_data", {out_samples, out_keep}, '0);
    chk("rst_count", sample_count, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run(runs[i]);

    // abort mid-run with a frame pending downstream
    in_valid = 1'b1; out_ready = 1'b1; rnd_data();
    pulse_start(32'd64);
    for (int c = 0; c < 10 && sample_count != 32'd24; c++) begin
      rnd_data();
      @(posedge clk); #1;
    end
    chk("clr_reach24", sample_count, 32'd24);
    chk("clr_pre_valid", out_valid, 1'b1);
    clear = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_ctrl", {out_valid, out_last, in_ready, busy, wav_done}, 5'b0);
    chk("clr_count", sample_count, '0);
    run('{ls: 20, mode: 0, frames: 3, last_keep: 8'h0F});

    // asynchronous reset between clock edges
    in_valid = 1'b1; out_ready = 1'b1; rnd_data();
    pulse_start(32'd64);
    repeat (3) begin rnd_data(); @(posedge clk); #1; end
    chk("arst_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", {in_ready, out_valid, out_last, busy, wav_done}, 5'b0);
    chk("arst_data", {out_samples, out_keep}, '0);
    chk("arst_count", sample_count, '0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run('{ls: 20, mode: 0, frames: 3, last_keep: 8'h0F});
    run('{ls: 12, mode: 0, frames: 2, last_keep: 8'h0F});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
